// File: rtl/pc_unit_pkg.sv
// Shared types and default parameters for the program-counter unit.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int          DEFAULT_WIDTH        = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_INC          = 4;
    localparam int          DEFAULT_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_wrap_adder.sv
// Wrapping incrementer: produces pc+INC (next sequential fetch) and
// pc+2*INC (the value software sees when it reads PC). Both wrap modulo 2^WIDTH.
module pc_wrap_adder
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int INC   = DEFAULT_INC
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc_inc2
);

    localparam logic [WIDTH-1:0] STEP  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] STEP2 = WIDTH'(2 * INC);

    assign pc_inc  = pc + STEP;
    assign pc_inc2 = pc + STEP2;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: drives the fetch address with a valid/ready handshake,
// takes branch redirects (flushing any unaccepted fetch) and supports halt/resume.
// Optional macro PC_UNIT_ALIGN_CHECK_EN adds a sticky align_fault output that
// rejects misaligned branch targets and parks the unit in HALT until reset.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int               INC          = DEFAULT_INC,
    parameter int               ALIGN_BITS   = DEFAULT_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_ready,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_plus,
    output logic             halted,
    output logic [WIDTH-1:0] fetch_count
`ifdef PC_UNIT_ALIGN_CHECK_EN
    ,
    output logic             align_fault
`endif
);

    pc_state_t        state;
    pc_state_t        state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] count_next;
    logic             accept;
    logic             target_ok;
    logic             resume_ok;

    pc_wrap_adder #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_adder (
        .pc      (pc),
        .pc_inc  (pc_inc),
        .pc_inc2 (pc_plus)
    );

    assign accept = pc_valid && pc_ready;
    assign halted = (state == HALT);

`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic fault_set;

    assign target_ok = ((branch_target & ALIGN_MASK) == '0);
    assign resume_ok = resume && !align_fault;
`else
    assign target_ok = 1'b1;
    assign resume_ok = resume;
`endif

    // Next-state, next-pc and fetch counting; a branch outranks halt and sequential advance.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = fetch_count;
`ifdef PC_UNIT_ALIGN_CHECK_EN
        fault_set  = 1'b0;
`endif
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (accept) begin
                    count_next = fetch_count + WIDTH'(1);
                end
                if (branch_valid) begin
                    if (target_ok) begin
                        pc_next = branch_target;
                    end else begin
                        state_next = HALT;
`ifdef PC_UNIT_ALIGN_CHECK_EN
                        fault_set  = 1'b1;
`endif
                    end
                end else if (accept) begin
                    pc_next = pc_inc;
                    if (halt_req) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (branch_valid) begin
                    if (target_ok) begin
                        pc_next = branch_target;
                        if (resume_ok) begin
                            state_next = RUN;
                        end
                    end else begin
`ifdef PC_UNIT_ALIGN_CHECK_EN
                        fault_set = 1'b1;
`endif
                    end
                end else if (resume_ok) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State, pc, registered pc_valid and fetch counter; reset discards any pending redirect or halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            pc_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pc_valid    <= (state_next == RUN);
            fetch_count <= count_next;
        end
    end

`ifdef PC_UNIT_ALIGN_CHECK_EN
    // Sticky alignment fault, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_fault <= 1'b0;
        end else if (fault_set) begin
            align_fault <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, async reset check,
// randomized run against a behavioural model, and the alignment-fault case
// when PC_UNIT_ALIGN_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_ready = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_plus;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef PC_UNIT_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int checks = 0;
    int errors = 0;

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .INC          (4),
        .ALIGN_BITS   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_ready      (pc_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_plus       (pc_plus),
        .halted        (halted),
        .fetch_count   (fetch_count)
`ifdef PC_UNIT_ALIGN_CHECK_EN
        ,
        .align_fault   (align_fault)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;

    mode_t       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    bit          m_fault;

    typedef struct {
        bit          bv;
        logic [31:0] tgt;
        bit          rdy;
        bit          hr;
        bit          rs;
        logic [31:0] e_pc;
        bit          e_valid;
        bit          e_halted;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic bit misaligned(logic [31:0] t);
`ifdef PC_UNIT_ALIGN_CHECK_EN
        return (t % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode  = M_BOOT;
        m_pc    = RV;
        m_count = 0;
        m_fault = 1'b0;
    endtask

    // Behavioural rules for one rising edge, using the inputs currently driven.
    task automatic model_edge();
        bit leave;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (pc_ready) m_count = m_count + 32'd1;
                if (branch_valid) begin
                    if (misaligned(branch_target)) begin
                        m_fault = 1'b1;
                        m_mode  = M_HALT;
                    end else begin
                        m_pc = branch_target;
                    end
                end else if (pc_ready) begin
                    m_pc = m_pc + 32'd4;
                    if (halt_req) m_mode = M_HALT;
                end
            end
            default: begin
                leave = resume && !m_fault;
                if (branch_valid && misaligned(branch_target)) begin
                    m_fault = 1'b1;
                end else begin
                    if (branch_valid) m_pc = branch_target;
                    if (leave) m_mode = M_RUN;
                end
            end
        endcase
    endtask

    task automatic check_val(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_output(string tag);
        check_val({tag, ".pc"}, pc, m_pc);
        check_val({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_mode == M_RUN});
        check_val({tag, ".halted"}, {31'b0, halted}, {31'b0, m_mode == M_HALT});
        check_val({tag, ".fetch_count"}, fetch_count, m_count);
        check_val({tag, ".pc_plus"}, pc_plus, m_pc + 32'd8);
`ifdef PC_UNIT_ALIGN_CHECK_EN
        check_val({tag, ".align_fault"}, {31'b0, align_fault}, {31'b0, m_fault});
`endif
    endtask

    task automatic apply_stimulus(bit bv, logic [31:0] tgt, bit rdy, bit hr, bit rs);
        branch_valid  = bv;
        branch_target = tgt;
        pc_ready      = rdy;
        halt_req      = hr;
        resume        = rs;
    endtask

    task automatic reset_sequence(int cycles);
        apply_stimulus(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_vectors();
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 32'd0});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h0,         1, 0, 32'd0});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h4,         1, 0, 32'd1});
        vecs.push_back('{0, 32'h0,         0, 0, 0, 32'h8,         1, 0, 32'd2});
        vecs.push_back('{0, 32'h0,         0, 0, 0, 32'h8,         1, 0, 32'd2});
        vecs.push_back('{0, 32'h0,         0, 0, 0, 32'h8,         1, 0, 32'd2});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h8,         1, 0, 32'd2});
        vecs.push_back('{1, 32'h100,       0, 0, 0, 32'hC,         1, 0, 32'd3});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h100,       1, 0, 32'd3});
        vecs.push_back('{0, 32'h0,         1, 1, 0, 32'h104,       1, 0, 32'd4});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h108,       0, 1, 32'd5});
        vecs.push_back('{0, 32'h0,         0, 0, 1, 32'h108,       0, 1, 32'd5});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'h108,       1, 0, 32'd5});
        vecs.push_back('{1, 32'hFFFF_FFFC, 0, 1, 0, 32'h10C,       1, 0, 32'd6});
        vecs.push_back('{0, 32'h0,         1, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'd6});
        vecs.push_back('{1, 32'h200,       1, 0, 0, 32'h0,         1, 0, 32'd7});
        vecs.push_back('{0, 32'h0,         0, 1, 0, 32'h200,       1, 0, 32'd8});
        vecs.push_back('{0, 32'h0,         1, 1, 0, 32'h200,       1, 0, 32'd8});
        vecs.push_back('{1, 32'h300,       0, 0, 0, 32'h204,       0, 1, 32'd9});
        vecs.push_back('{1, 32'h400,       0, 0, 1, 32'h300,       0, 1, 32'd9});
        vecs.push_back('{0, 32'h0,         0, 0, 0, 32'h400,       1, 0, 32'd9});
    endtask

    initial begin
        logic [31:0] tgt;
        fill_vectors();

        apply_stimulus(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset.pc", pc, RV);
        check_val("reset.pc_valid", {31'b0, pc_valid}, 32'd0);
        check_val("reset.halted", {31'b0, halted}, 32'd0);
        check_val("reset.fetch_count", fetch_count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].bv, vecs[i].tgt, vecs[i].rdy, vecs[i].hr, vecs[i].rs);
            @(negedge clk);
            check_val($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
            check_val($sformatf("vec%0d.pc_valid", i), {31'b0, pc_valid}, {31'b0, vecs[i].e_valid});
            check_val($sformatf("vec%0d.halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
            check_val($sformatf("vec%0d.fetch_count", i), fetch_count, vecs[i].e_count);
            check_val($sformatf("vec%0d.pc_plus", i), pc_plus, vecs[i].e_pc + 32'd8);
            model_edge();
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset.pc", pc, RV);
        check_val("async_reset.pc_valid", {31'b0, pc_valid}, 32'd0);
        check_val("async_reset.fetch_count", fetch_count, 32'd0);
        check_val("async_reset.halted", {31'b0, halted}, 32'd0);
        reset_sequence(1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_output($sformatf("rnd%0d_rst", i));
                @(posedge clk);
                #1 rst_n = 1'b1;
                continue;
            end
            tgt = $urandom();
`ifdef PC_UNIT_ALIGN_CHECK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            apply_stimulus($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            @(negedge clk);
            check_output($sformatf("rnd%0d", i));
            model_edge();
            @(posedge clk);
            #1;
        end

`ifdef PC_UNIT_ALIGN_CHECK_EN
        reset_sequence(2);
        apply_stimulus(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 apply_stimulus(1, 32'h102, 0, 0, 0);
        @(posedge clk);
        #1 apply_stimulus(0, 0, 0, 0, 1);
        @(negedge clk);
        check_val("align.pc", pc, RV);
        check_val("align.fault", {31'b0, align_fault}, 32'd1);
        check_val("align.halted", {31'b0, halted}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("align.resume_ignored", {31'b0, halted}, 32'd1);
        check_val("align.still_invalid", {31'b0, pc_valid}, 32'd0);
        check_val("align.sticky", {31'b0, align_fault}, 32'd1);
        reset_sequence(1);
        @(negedge clk);
        check_val("align.cleared", {31'b0, align_fault}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the ARM controller. It generalises the single-cycle PC register into the following:
- configurable width, reset vector and increment
- a valid/ready fetch handshake
- branch redirect with flush
- a halt/resume state machine

It sits between the controller's next-PC logic and instruction memory and drives the fetch address every cycle.

Parameters:
WIDTH, 32, PC and target width in bits (>= 8)
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset and on BOOT
INC, 4, byte increment applied per accepted fetch
ALIGN_BITS, 2, low PC bits that must be zero (used by the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_ready  in  1  instruction memory accepts current pc this cycle
branch_valid  in  1  redirect request
branch_target  in  WIDTH  redirect address
halt_req  in  1  request halt at next accept boundary
resume  in  1  leave HALT
pc  out  WIDTH  current fetch address
pc_valid  out  1  pc is a valid fetch request
pc_plus  out  WIDTH  pc + 2*INC, combinational (ARM PC-read value)
halted  out  1  state == HALT
fetch_count  out  WIDTH  number of accepted fetches, wraps modulo 2^WIDTH

Behaviour:
- Reset (rst_n low, asynchronous), applied immediately regardless of clk:
  - pc = RESET_VECTOR, pc_valid = 0, halted = 0, fetch_count = 0, state = BOOT.
  - Reset asserted mid-operation discards any pending redirect or halt.
- State BOOT: lasts exactly one cycle after rst_n is sampled high, then moves to RUN. pc_valid = 0. Inputs are ignored.
- State RUN: pc_valid = 1. Priority per rising edge, highest first:
  1. branch_valid: pc <= branch_target. A non-accepted current pc is dropped (flush). fetch_count increments only if pc_ready is also 1. The state stays RUN even if halt_req = 1; the halt is re-evaluated next cycle.
  2. halt_req && pc_ready: the current fetch is accepted, pc <= pc + INC, fetch_count++, state <= HALT.
  3. pc_ready: pc <= pc + INC, fetch_count++.
  4. Otherwise pc holds and pc_valid stays 1 (stall). pc must not change while valid && !ready unless a branch occurs.
- State HALT: pc_valid = 0, pc holds, halted = 1.
  - resume moves to RUN next cycle.
  - branch_valid in HALT updates pc but stays in HALT.
  - resume and branch_valid together: pc <= target and state <= RUN.
- pc_valid is registered. A fetch is accepted only when pc_valid && pc_ready.
- Arithmetic:
  - pc + INC and pc + 2*INC are WIDTH-bit and wrap silently, e.g. WIDTH=32, pc=32'hFFFF_FFFC, INC=4 -> 0.
  - branch_target is used as-is (no sign extension).
- Latency: a redirect issued in cycle N appears on pc in cycle N+1, with pc_valid = 1 if in RUN.

Optional Feature:
Macro PC_UNIT_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_fault (1 bit, reset 0, sticky until reset).
  - A branch_valid whose target has any of the low ALIGN_BITS bits set is rejected: pc is unchanged, align_fault <= 1, state <= HALT.
  - resume does not leave HALT while align_fault = 1.
- Undefined: no align_fault port; targets are loaded unchecked.

Decomposition:
- Package pc_unit_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t
  - localparam default widths and the RESET_VECTOR default
- One sub-module is natural: pc_wrap_adder (WIDTH-parametrised incrementer producing pc+INC and pc+2*INC). All else stays inline.

Test Plan:
- Reset/boot:
  - rst_n low for 3 cycles, then high -> pc = 0, pc_valid = 0 for one cycle.
  - Then pc_valid = 1 with pc = 0, 4, 8, 12 on consecutive cycles with pc_ready = 1.
  - fetch_count = 4 after four accepts.
- Stall: pc_ready = 0 for 3 cycles at pc = 8 -> pc holds at 8 and pc_valid stays 1. Raise pc_ready -> pc = 12 next cycle.
- Redirect: branch_valid = 1, target = 32'h100 while pc_ready = 0 at pc = 12 -> next pc = 32'h100, pc_valid = 1, fetch_count unchanged, pc_plus = 32'h108.
- Halt/resume:
  - halt_req with pc_ready at pc = 32'h104 -> pc = 32'h108, halted = 1, pc_valid = 0.
  - resume -> RUN; pc = 32'h108 is presented next cycle.
- Wrap and async reset:
  - branch to 32'hFFFF_FFFC then accept -> pc = 0.
  - Assert rst_n low mid-cycle -> pc = RESET_VECTOR immediately, without waiting for a clock edge.
- Optional feature (PC_UNIT_ALIGN_CHECK_EN defined): branch target 32'h102 -> pc unchanged, align_fault = 1, halted = 1. resume is ignored until reset.
